psum_relu_pool: RTL
===================

# psum_relu_pool

Post-processing stage directly downstream of the pooling/non-linearity adder tree. Each cycle `in_valid` is high, it takes one signed partial sum from the tree output. It accumulates `cfg_passes` partial sums into one output pixel, then saturates the pixel and optionally applies ReLU. It max-pools `cfg_pool` consecutive pixels into one result, which leaves through a 2-entry valid/ready output buffer toward the output writeback.

## Interface
Parameters:
- `WID`, 16: data width of `in_data` and `out_data` (matches the adder tree output width).
- `ACC_GUARD`, 8: extra accumulator bits; accumulator width is `WID+ACC_GUARD`.

Ports (`rst` is asynchronous, active-high; clock is `clk`):
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous active-high reset.
- `cfg_load`  in  1  latches `cfg_passes`/`cfg_pool` and restarts the pixel/pool state.
- `cfg_passes`  in  8  partial sums per pixel; 0 is treated as 1.
- `cfg_pool`  in  3  pixels per pool group; 0 is treated as 1.
- `in_valid`  in  1  `in_data` is valid this cycle. It cannot be stalled: the adder tree has no backpressure.
- `in_data`  in  `WID`  signed partial sum from the adder tree.
- `out_valid`  out  1  the buffer head is valid.
- `out_ready`  in  1  consumer accepts the head.
- `out_data`  out  `WID`  pooled result, signed.
- `busy`  out  1  state is RUN or the buffer is non-empty.
- `sat_flag`  out  1  sticky: a pixel saturated.
- `drop_flag`  out  1  sticky: a result was dropped because the buffer was full.

## Operation
- FSM states are IDLE and RUN. Reset enters IDLE.
  - IDLE → RUN on `cfg_load`.
  - `cfg_load` in RUN restarts: latches the config and clears the pass counter, pool counter, accumulator and running max. Buffer contents are kept.
  - `in_valid` is ignored in IDLE and in any cycle where `cfg_load` is high.
- Accumulation:
  - `acc` is signed, width `WID+ACC_GUARD`. `in_data` is sign-extended.
  - `sum = acc + in_data`. On a non-final pass, `acc <= sum` and `pass_cnt` increments.
  - On the final pass (`pass_cnt == passes-1`), `acc` and `pass_cnt` clear to 0.
- Pixel finalise (final pass, combinational on `sum`):
  - Saturate to [-2^(WID-1), 2^(WID-1)-1].
  - If clamping occurs, set `sat_flag`.
  - Then apply ReLU when enabled (see Configuration).
- Pooling:
  - The first pixel of a group loads `pmax`. Later pixels do `pmax <= max(pmax, pixel)` as a signed compare.
  - On the pixel with `pool_cnt == pool-1`, the result `max(pmax, pixel)` (or `pixel` if pool=1) is pushed into the buffer, and `pool_cnt` clears.
- Output buffer:
  - 2-entry FIFO. Head is on `out_data`; `out_valid` = not empty.
  - A pop happens when `out_valid && out_ready`.
  - Push and pop in the same cycle are both performed, including when the buffer is full.
  - A push when full without a pop is dropped and sets `drop_flag`.
- `sat_flag` and `drop_flag` clear only on `rst` or `cfg_load`.

## Timing
- Reset values:
  - `out_valid` = 0, `out_data` = 0, `busy` = 0, `sat_flag` = 0, `drop_flag` = 0.
  - All counters, `acc` and `pmax` = 0. FSM = IDLE.
- Latency: result is visible on `out_data` with `out_valid` = 1 in the cycle after the clock edge that samples the completing `in_valid` beat (buffer empty).
- Throughput: one `in_data` per cycle with no bubbles. When passes=1 and pool=1, one result per cycle.
- `out_data` holds stable while `out_valid && !out_ready`.
- `rst` mid-operation: all state clears immediately, including buffer contents.

## Configuration
- `PSUM_RELU_EN` defined: the saturated pixel is clamped so negative values become 0 before pooling. A pool group of all-negative pixels therefore yields 0.
- `PSUM_RELU_EN` undefined: the saturated pixel passes signed, and pooling is a signed max, so negative results are possible.

## Test plan
- passes=3, pool=1; inputs 10, 20, -5 → `out_data`=25, `out_valid` 1 cycle after the third beat; `sat_flag`=0.
- passes=2, pool=1; inputs 30000, 30000 → `out_data`=32767, `sat_flag`=1. Then inputs -30000, -30000 → -32768 without `PSUM_RELU_EN`, 0 with it.
- passes=1, pool=4; inputs 5, -7, 12, 3 → single result 12 after the 4th beat; no `out_valid` before it.
- passes=1, pool=1, `out_ready`=0; inputs 1, 2, 3 → buffer holds 1, 2; `drop_flag`=1. Then `out_ready`=1 → 1 then 2, then `out_valid`=0.
- passes=2, pool=2; `cfg_load` after 3 beats, then inputs 4, 4, 1, 1 → single result 8; pre-load partial state never appears.
- `rst` asserted with 1 entry buffered and `acc` non-zero → `out_valid` drops asynchronously, `busy`=0, FSM IDLE; `in_valid` is ignored until `cfg_load`.

Source files
------------

// File: rtl/psum_relu_pool.sv
// psum_relu_pool
//   Post-processing stage after the adder tree. It accumulates cfg_passes
//   signed partial sums into one pixel, saturates the pixel to WID bits and
//   optionally applies ReLU. It then max-pools cfg_pool pixels into one
//   result, which goes into a 2-entry valid/ready buffer.
//
//   Optional feature: define PSUM_RELU_EN to clamp negative pixels to 0
//   before pooling. Without it, pixels pass signed.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   cfg_load        latch cfg_passes/cfg_pool, restart pixel/pool state
//   cfg_passes[7:0] partial sums per pixel (0 -> 1)
//   cfg_pool[2:0]   pixels per pool group (0 -> 1)
//   in_valid        in_data valid (no backpressure on the adder tree)
//   in_data[WID]    signed partial sum
//   out_valid       buffer head valid
//   out_ready       consumer accepts the head
//   out_data[WID]   pooled result (signed)
//   busy            RUN state or buffer non-empty
//   sat_flag        sticky: a pixel saturated
//   drop_flag       sticky: a result was dropped on a full buffer
module psum_relu_pool #(
  parameter int WID       = 16,
  parameter int ACC_GUARD = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_load,
  input  logic [7:0]            cfg_passes,
  input  logic [2:0]            cfg_pool,
  input  logic                  in_valid,
  input  logic signed [WID-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic signed [WID-1:0] out_data,
  output logic                  busy,
  output logic                  sat_flag,
  output logic                  drop_flag
);
  localparam int AW = WID + ACC_GUARD;

  // Saturation bounds expressed at accumulator width.
  localparam logic signed [AW-1:0] SMAX = {{(ACC_GUARD+1){1'b0}}, {(WID-1){1'b1}}};
  localparam logic signed [AW-1:0] SMIN = {{(ACC_GUARD+1){1'b1}}, {(WID-1){1'b0}}};

  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;

  logic [7:0]            passes_q, pass_cnt;
  logic [2:0]            pool_q, pool_cnt;
  logic signed [AW-1:0]  acc, in_ext, sum;
  logic signed [WID-1:0] pixel_sat, pixel, pmax, result;
  logic                  accept, last_pass, last_px, clamp_hi, clamp_lo;

  // Output buffer: two entries with pointers and an occupancy count.
  logic [1:0][WID-1:0] mem;
  logic                rd_ptr, wr_ptr;
  logic [1:0]          count;
  logic                full, push, pop, wr_en, drop;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (cfg_load) state_d = RUN;
  end

  // ---------------- pixel datapath ----------------
  // A beat is taken only in RUN and never in the cycle of a cfg_load.
  assign accept    = (state_q == RUN) && in_valid && !cfg_load;
  assign last_pass = (pass_cnt == passes_q - 8'd1);
  assign last_px   = (pool_cnt == pool_q - 3'd1);
  assign in_ext    = {{ACC_GUARD{in_data[WID-1]}}, in_data};
  assign sum       = acc + in_ext;
  assign clamp_hi  = (sum > SMAX);
  assign clamp_lo  = (sum < SMIN);

  always_comb begin
    pixel_sat = sum[WID-1:0];
    if (clamp_hi)      pixel_sat = {1'b0, {(WID-1){1'b1}}};
    else if (clamp_lo) pixel_sat = {1'b1, {(WID-1){1'b0}}};
  end

`ifdef PSUM_RELU_EN
  assign pixel = pixel_sat[WID-1] ? '0 : pixel_sat;
`else
  assign pixel = pixel_sat;
`endif

  // First pixel of a group ignores the stale pmax.
  assign result = (pool_cnt == 3'd0) ? pixel : ((pixel > pmax) ? pixel : pmax);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      passes_q <= '0;
      pool_q   <= '0;
      pass_cnt <= '0;
      pool_cnt <= '0;
      acc      <= '0;
      pmax     <= '0;
    end else if (cfg_load) begin
      passes_q <= (cfg_passes == 8'd0) ? 8'd1 : cfg_passes;
      pool_q   <= (cfg_pool == 3'd0) ? 3'd1 : cfg_pool;
      pass_cnt <= '0;
      pool_cnt <= '0;
      acc      <= '0;
      pmax     <= '0;
    end else if (accept) begin
      if (last_pass) begin
        acc      <= '0;
        pass_cnt <= '0;
        pmax     <= result;
        pool_cnt <= last_px ? 3'd0 : pool_cnt + 3'd1;
      end else begin
        acc      <= sum;
        pass_cnt <= pass_cnt + 8'd1;
      end
    end
  end

  // ---------------- output buffer ----------------
  assign full  = (count == 2'd2);
  assign push  = accept && last_pass && last_px;
  assign pop   = (count != 2'd0) && out_ready;
  // When full, a same-cycle pop frees the slot being written.
  assign wr_en = push && (!full || pop);
  assign drop  = push && full && !pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem    <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= result;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, wr_en} - {1'b0, pop};
    end
  end

  assign out_valid = (count != 2'd0);
  assign out_data  = mem[rd_ptr];
  assign busy      = (state_q == RUN) || (count != 2'd0);

  // ---------------- sticky flags ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_flag  <= 1'b0;
      drop_flag <= 1'b0;
    end else if (cfg_load) begin
      sat_flag  <= 1'b0;
      drop_flag <= 1'b0;
    end else begin
      if (accept && last_pass && (clamp_hi || clamp_lo)) sat_flag <= 1'b1;
      if (drop) drop_flag <= 1'b1;
    end
  end
endmodule
